// File: rtl/tanh_interp_scheduler.sv
// tanh_interp_scheduler: round-robin scheduler sharing one tanh table and one linear interpolator among N_REQ requesters.
// Optional feature macro: TANH_SAT_EN (saturated operands bypass the table and answer one cycle after grant).
module tanh_interp_scheduler #(
    parameter int N_REQ  = 4,
    parameter int W      = 8,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*W-1:0]   z__in,
    output logic [N_REQ-1:0]     ack,
    output logic [W-1:0]         res__data,
    output logic                 tbl__en,
    output logic [ADDR_W-1:0]    tbl__addr,
    input  logic [W-1:0]         tbl__data,
    output logic [W-1:0]         ip__z,
    output logic [W-1:0]         ip__base,
    output logic [W-1:0]         ip__next,
    output logic [W-1:0]         ip__int,
    input  logic [W-1:0]         ip__value
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [W-1:0] INT_MASK = {{(W-4){1'b1}}, 4'b0000};

    typedef enum logic [2:0] {IDLE, RD_BASE, RD_NEXT, WAIT, EVAL, RESP} state_t;

    state_t             state_q, state_d;
    logic [GW-1:0]      p_q, p_d;
    logic [GW-1:0]      g_q, g_d;
    logic [W-1:0]       z_q, z_d;
    logic [W-1:0]       base_q, base_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [W-1:0]       res_q, res_d;
    logic               tbl_en_q, tbl_en_d;
    logic [ADDR_W-1:0]  tbl_addr_q, tbl_addr_d;
    logic [W-1:0]       ipz_q, ipz_d;
    logic [W-1:0]       ipb_q, ipb_d;
    logic [W-1:0]       ipn_q, ipn_d;
    logic [W-1:0]       ipi_q, ipi_d;

    logic               found;
    logic [GW-1:0]      gsel;
    logic [W-1:0]       z_sel;
    logic [ADDR_W-1:0]  a_sel;
    logic               sat_hi, sat_lo;

    // Round-robin scan: first asserted request at or after the pointer, wrapping upward.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[(int'(p_q) + k) % N_REQ]) begin
                found = 1'b1;
                gsel  = GW'((int'(p_q) + k) % N_REQ);
            end
        end
    end

    // Operand of the candidate requester, its base table address and saturation class.
    always_comb begin
        z_sel = z__in[int'(gsel)*W +: W];
        a_sel = ADDR_W'($signed(z_sel) >>> 4) + ADDR_W'(8);
`ifdef TANH_SAT_EN
        sat_hi = $signed(z_sel) >= $signed(W'(48));
        sat_lo = $signed(z_sel) <= -$signed(W'(48));
`else
        sat_hi = 1'b0;
        sat_lo = 1'b0;
`endif
    end

    // FSM next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        g_d        = g_q;
        z_d        = z_q;
        base_d     = base_q;
        ack_d      = ack_q;
        res_d      = res_q;
        tbl_en_d   = tbl_en_q;
        tbl_addr_d = tbl_addr_q;
        ipz_d      = ipz_q;
        ipb_d      = ipb_q;
        ipn_d      = ipn_q;
        ipi_d      = ipi_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    g_d = gsel;
                    z_d = z_sel;
                    p_d = (gsel == GW'(N_REQ - 1)) ? '0 : gsel + GW'(1);
                    if (sat_hi || sat_lo) begin
                        res_d   = sat_hi ? W'(16) : -W'(16);
                        ack_d   = N_REQ'(1) << gsel;
                        state_d = RESP;
                    end else begin
                        tbl_en_d   = 1'b1;
                        tbl_addr_d = a_sel;
                        state_d    = RD_BASE;
                    end
                end
            end
            RD_BASE: begin
                tbl_addr_d = tbl_addr_q + ADDR_W'(1);
                state_d    = RD_NEXT;
            end
            RD_NEXT: begin
                base_d   = tbl__data;
                tbl_en_d = 1'b0;
                state_d  = WAIT;
            end
            WAIT: begin
                ipz_d   = z_q;
                ipb_d   = base_q;
                ipn_d   = tbl__data;
                ipi_d   = z_q & INT_MASK;
                state_d = EVAL;
            end
            EVAL: begin
                res_d   = ip__value;
                ack_d   = N_REQ'(1) << g_q;
                state_d = RESP;
            end
            RESP: begin
                ack_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any operation without an ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            p_q        <= '0;
            g_q        <= '0;
            z_q        <= '0;
            base_q     <= '0;
            ack_q      <= '0;
            res_q      <= '0;
            tbl_en_q   <= 1'b0;
            tbl_addr_q <= '0;
            ipz_q      <= '0;
            ipb_q      <= '0;
            ipn_q      <= '0;
            ipi_q      <= '0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            g_q        <= g_d;
            z_q        <= z_d;
            base_q     <= base_d;
            ack_q      <= ack_d;
            res_q      <= res_d;
            tbl_en_q   <= tbl_en_d;
            tbl_addr_q <= tbl_addr_d;
            ipz_q      <= ipz_d;
            ipb_q      <= ipb_d;
            ipn_q      <= ipn_d;
            ipi_q      <= ipi_d;
        end
    end

    assign ack       = ack_q;
    assign res__data = res_q;
    assign tbl__en   = tbl_en_q;
    assign tbl__addr = tbl_addr_q;
    assign ip__z     = ipz_q;
    assign ip__base  = ipb_q;
    assign ip__next  = ipn_q;
    assign ip__int   = ipi_q;

endmodule

// File: doc/tanh_interp_scheduler.md
# tanh_interp_scheduler

Time-multiplexes one tanh lookup table and one combinational linear interpolator (8-bit signed Q4.4, table at integer points, fraction weight shifted right by 4) among N activation requesters. A round-robin arbiter grants one request at a time. An FSM reads the two bracketing table entries, drives the interpolator operands, and returns the result with a one-cycle acknowledge pulse. The block sits between the neuron output stages and the shared tanh table/interpolator pair.

## Interface
- N_REQ, 4, number of requesters (2..8)
- W, 8, data width (Q4.4 signed)
- ADDR_W, 5, table address width (table depth 17)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  N_REQ  request per requester; held high until matching ack
- z__in  in  N_REQ*W  operand per requester, slice i = bits [i*W +: W]; stable while req[i] high
- ack  out  N_REQ  one-hot, one-cycle completion pulse
- res__data  out  W  result; valid in the ack cycle, held until next result
- tbl__en  out  1  table read strobe
- tbl__addr  out  ADDR_W  table address
- tbl__data  in  W  table read data, 1-cycle latency after tbl__en
- ip__z, ip__base, ip__next, ip__int  out  W each  interpolator operands (z value, base, next data, integer part)
- ip__value  in  W  interpolated value (combinational from ip__* operands)

## Operation
- Table entry k holds tanh(k-8) in Q4.4 for k = 0..16; entry 16 = 8'h10.
- Address rule: a = (z >>> 4) + 8, range 0..15. Next address = a+1, always 1..16, never wraps.
- Integer part rule: ip__int = z & 8'hF0, which is floor in Q4.4, two's complement.
- Arbiter: in IDLE, grants the first asserted req at or after pointer p, scanning upward with wrap. On grant, latches z and grant index g, and sets p = (g+1) mod N_REQ. p resets to 0.
- FSM states:
  - IDLE: grant → RD_BASE.
  - RD_BASE: tbl__en=1, tbl__addr=a → RD_NEXT.
  - RD_NEXT: tbl__en=1, tbl__addr=a+1, capture tbl__data as base → WAIT.
  - WAIT: capture tbl__data as next → EVAL.
  - EVAL: ip__* driven from registers, capture ip__value → RESP.
  - RESP: ack[g]=1, res__data valid → IDLE.
- Outside RD_BASE and RD_NEXT: tbl__en=0, tbl__addr holds its last value.
- No new grant in RESP. The requester sees ack and drops req in the following cycle. Earliest re-grant is the cycle after RESP.
- If req[g] drops before ack (protocol violation), the operation still completes and ack[g] still pulses.
- Requests arriving while busy wait; no request is lost; round-robin guarantees service within N_REQ operations.

## Timing
- Registered outputs; reset values: ack=0, res__data=0, tbl__en=0, tbl__addr=0, all ip__*=0, state IDLE, p=0.
- Latency: grant cycle T, ack in T+5 (table path). Throughput: one result per 6 cycles.
- Simultaneous req from multiple requesters: exactly one grant per IDLE cycle, chosen by the pointer scan.
- Reset asserted mid-operation: immediate return to IDLE, no ack for the aborted operation, pointer 0. The requester must reissue its request.
- ip__* stable from EVAL through RESP; res__data captured at the end of EVAL.

## Configuration
- TANH_SAT_EN defined: in the grant cycle, z ≥ 8'h30 (+3.0) loads res__data = 8'h10 and z ≤ 8'hD0 (-3.0) loads res__data = 8'hF0. The FSM then goes directly to RESP, so ack arrives at T+1, with no table access and ip__* unchanged.
- TANH_SAT_EN undefined: all operands take the table path with T+5 latency.

## Test plan
- Single request: req[0], z=8'h08, table entry 8 = 0, entry 9 = 8'h0C → tbl__addr 8 then 9, ip__int=8'h00, ack[0] at T+5, res__data=8'h06.
- Negative operand: z=8'hF8 (-0.5), entry 7 = 8'hF4, entry 8 = 0 → addresses 7 and 8, ip__int=8'hF0, res__data = interpolator output, ack at T+5.
- Contention: req=4'b1111 held throughout → grants in order 0,1,2,3,0, one ack every 6 cycles, never two ack bits high together.
- Upper boundary: z=8'h7F → addresses 15 and 16, no wrap to 0; result computed from entries 15 and 16.
- Reset at RD_NEXT → all outputs 0 next cycle, no ack, next grant starts from requester 0.
- TANH_SAT_EN: z=8'h40 → res__data=8'h10 and ack at T+1 with tbl__en never high; z=8'hC0 → 8'hF0. Without the macro, z=8'h40 takes the table path with ack at T+5.
